// File: rtl/commit_rob.sv
// In-order commit window over an out-of-order completion buffer; issue/writeback visible next cycle.
// Issue stalls on registered fullness only (a same-cycle pop never frees a slot); acks pop in order.
module commit_rob #(
  parameter int NR_ENTRIES      = 8,
  parameter int NR_COMMIT_PORTS = 2,
  parameter int NR_WB_PORTS     = 2,
  parameter int XLEN            = 64,
  parameter int VLEN            = 39,
  parameter int TRANS_ID_BITS   = $clog2(NR_ENTRIES)
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          flush_i,
  input  logic                                          issue_valid_i,
  output logic                                          issue_ready_o,
  output logic [TRANS_ID_BITS-1:0]                      issue_trans_id_o,
  input  logic [VLEN-1:0]                               issue_pc_i,
  input  logic [4:0]                                    issue_rd_i,
  input  logic [3:0]                                    issue_fu_i,
  input  logic [6:0]                                    issue_op_i,
  input  logic                                          issue_ex_valid_i,
  input  logic [XLEN-1:0]                               issue_ex_cause_i,
  input  logic [XLEN-1:0]                               issue_ex_tval_i,
  input  logic [NR_WB_PORTS-1:0]                        wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]     wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][XLEN-1:0]              wb_data_i,
  input  logic [NR_WB_PORTS-1:0]                        wb_ex_valid_i,
  input  logic [NR_WB_PORTS-1:0][XLEN-1:0]              wb_ex_cause_i,
  input  logic [NR_WB_PORTS-1:0][XLEN-1:0]              wb_ex_tval_i,
  output logic [NR_COMMIT_PORTS-1:0]                    commit_valid_o,
  output logic [NR_COMMIT_PORTS-1:0][VLEN-1:0]          commit_pc_o,
  output logic [NR_COMMIT_PORTS-1:0][4:0]               commit_rd_o,
  output logic [NR_COMMIT_PORTS-1:0][3:0]               commit_fu_o,
  output logic [NR_COMMIT_PORTS-1:0][6:0]               commit_op_o,
  output logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]          commit_result_o,
  output logic [NR_COMMIT_PORTS-1:0]                    commit_ex_valid_o,
  output logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]          commit_ex_cause_o,
  output logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]          commit_ex_tval_o,
  output logic [NR_COMMIT_PORTS-1:0][TRANS_ID_BITS-1:0] commit_trans_id_o,
  input  logic [NR_COMMIT_PORTS-1:0]                    commit_ack_i,
  output logic                                          empty_o
);

  localparam int CW = TRANS_ID_BITS + 1;

  typedef logic [TRANS_ID_BITS-1:0] tag_t;
  typedef logic [CW-1:0]            cnt_t;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic [4:0]      rd;
    logic [3:0]      fu;
    logic [6:0]      op;
    logic [XLEN-1:0] result;
    logic            ex_valid;
    logic [XLEN-1:0] ex_cause;
    logic [XLEN-1:0] ex_tval;
  } entry_t;

  entry_t                entry_q [NR_ENTRIES];
  entry_t                entry_d [NR_ENTRIES];
  logic [NR_ENTRIES-1:0] occ_q, occ_d;
  logic [NR_ENTRIES-1:0] done_q, done_d;
  tag_t                  head_q, head_d;
  tag_t                  tail_q, tail_d;
  cnt_t                  count_q, count_d;

  logic       issue_fire;
  logic       pop0, pop1;
  logic [1:0] pops;
  tag_t       slot_idx [NR_COMMIT_PORTS];

  assign issue_ready_o    = (count_q != cnt_t'(NR_ENTRIES));
  assign issue_trans_id_o = tail_q;
  assign empty_o          = (count_q == '0);
  assign issue_fire       = issue_valid_i & issue_ready_o;

  // Window is purely registered; slot i needs i older entries present ahead of it.
  always_comb begin
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      slot_idx[i]          = head_q + tag_t'(i);
      commit_valid_o[i]    = occ_q[slot_idx[i]] & done_q[slot_idx[i]] & (count_q > cnt_t'(i));
      commit_pc_o[i]       = entry_q[slot_idx[i]].pc;
      commit_rd_o[i]       = entry_q[slot_idx[i]].rd;
      commit_fu_o[i]       = entry_q[slot_idx[i]].fu;
      commit_op_o[i]       = entry_q[slot_idx[i]].op;
      commit_result_o[i]   = entry_q[slot_idx[i]].result;
      commit_ex_valid_o[i] = entry_q[slot_idx[i]].ex_valid;
      commit_ex_cause_o[i] = entry_q[slot_idx[i]].ex_cause;
      commit_ex_tval_o[i]  = entry_q[slot_idx[i]].ex_tval;
      commit_trans_id_o[i] = occ_q[slot_idx[i]] ? slot_idx[i] : '0;
    end
  end

  assign pop0 = commit_ack_i[0] & commit_valid_o[0];
  assign pop1 = pop0 & commit_ack_i[1] & commit_valid_o[1];
  assign pops = {1'b0, pop0} + {1'b0, pop1};

  always_comb begin
    entry_d = entry_q;
    occ_d   = occ_q;
    done_d  = done_q;
    head_d  = head_q + tag_t'(pops);
    tail_d  = tail_q;
    count_d = count_q + cnt_t'(issue_fire) - cnt_t'(pops);

    if (issue_fire) begin
      entry_d[tail_q].pc       = issue_pc_i;
      entry_d[tail_q].rd       = issue_rd_i;
      entry_d[tail_q].fu       = issue_fu_i;
      entry_d[tail_q].op       = issue_op_i;
      entry_d[tail_q].result   = '0;
      entry_d[tail_q].ex_valid = issue_ex_valid_i;
      entry_d[tail_q].ex_cause = issue_ex_cause_i;
      entry_d[tail_q].ex_tval  = issue_ex_tval_i;
      occ_d[tail_q]            = 1'b1;
      done_d[tail_q]           = issue_ex_valid_i;
      tail_d                   = tail_q + tag_t'(1);
    end

    // Ascending port order lets the higher port win a same-tag collision.
    for (int k = 0; k < NR_WB_PORTS; k++) begin
      if (wb_valid_i[k] && occ_q[wb_trans_id_i[k]]) begin
        done_d[wb_trans_id_i[k]]         = 1'b1;
        entry_d[wb_trans_id_i[k]].result = wb_data_i[k];
        if (wb_ex_valid_i[k]) begin
          entry_d[wb_trans_id_i[k]].ex_valid = 1'b1;
          entry_d[wb_trans_id_i[k]].ex_cause = wb_ex_cause_i[k];
          entry_d[wb_trans_id_i[k]].ex_tval  = wb_ex_tval_i[k];
        end
      end
    end

    if (pop0) begin
      occ_d[slot_idx[0]]  = 1'b0;
      done_d[slot_idx[0]] = 1'b0;
    end
    if (pop1) begin
      occ_d[slot_idx[1]]  = 1'b0;
      done_d[slot_idx[1]] = 1'b0;
    end

    if (flush_i) begin
      occ_d   = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entry_q <= '{default: '0};
      occ_q   <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entry_q <= entry_d;
      occ_q   <= occ_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_commit_rob.sv
// Directed scenarios for commit_rob; inputs change and outputs are sampled 1ns after each rising edge.
module tb_commit_rob;

  localparam int NE = 8;
  localparam int XL = 64;
  localparam int VL = 39;
  localparam int TB = 3;

  logic              clk_i = 1'b0;
  logic              rst_i, flush_i;
  logic              issue_valid_i, issue_ready_o;
  logic [TB-1:0]     issue_trans_id_o;
  logic [VL-1:0]     issue_pc_i;
  logic [4:0]        issue_rd_i;
  logic [3:0]        issue_fu_i;
  logic [6:0]        issue_op_i;
  logic              issue_ex_valid_i;
  logic [XL-1:0]     issue_ex_cause_i, issue_ex_tval_i;
  logic [1:0]        wb_valid_i, wb_ex_valid_i;
  logic [1:0][TB-1:0] wb_trans_id_i;
  logic [1:0][XL-1:0] wb_data_i, wb_ex_cause_i, wb_ex_tval_i;
  logic [1:0]        commit_valid_o, commit_ex_valid_o, commit_ack_i;
  logic [1:0][VL-1:0] commit_pc_o;
  logic [1:0][4:0]   commit_rd_o;
  logic [1:0][3:0]   commit_fu_o;
  logic [1:0][6:0]   commit_op_o;
  logic [1:0][XL-1:0] commit_result_o, commit_ex_cause_o, commit_ex_tval_o;
  logic [1:0][TB-1:0] commit_trans_id_o;
  logic              empty_o;

  int n_tests = 0;
  int n_fail  = 0;

  commit_rob #(.NR_ENTRIES(NE), .NR_COMMIT_PORTS(2), .NR_WB_PORTS(2), .XLEN(XL), .VLEN(VL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_trans_id_o(issue_trans_id_o),
    .issue_pc_i(issue_pc_i), .issue_rd_i(issue_rd_i), .issue_fu_i(issue_fu_i), .issue_op_i(issue_op_i),
    .issue_ex_valid_i(issue_ex_valid_i), .issue_ex_cause_i(issue_ex_cause_i), .issue_ex_tval_i(issue_ex_tval_i),
    .wb_valid_i(wb_valid_i), .wb_trans_id_i(wb_trans_id_i), .wb_data_i(wb_data_i),
    .wb_ex_valid_i(wb_ex_valid_i), .wb_ex_cause_i(wb_ex_cause_i), .wb_ex_tval_i(wb_ex_tval_i),
    .commit_valid_o(commit_valid_o), .commit_pc_o(commit_pc_o), .commit_rd_o(commit_rd_o),
    .commit_fu_o(commit_fu_o), .commit_op_o(commit_op_o), .commit_result_o(commit_result_o),
    .commit_ex_valid_o(commit_ex_valid_o), .commit_ex_cause_o(commit_ex_cause_o),
    .commit_ex_tval_o(commit_ex_tval_o), .commit_trans_id_o(commit_trans_id_o),
    .commit_ack_i(commit_ack_i), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    flush_i = 1'b0; issue_valid_i = 1'b0; issue_pc_i = '0; issue_rd_i = '0; issue_fu_i = '0;
    issue_op_i = '0; issue_ex_valid_i = 1'b0; issue_ex_cause_i = '0; issue_ex_tval_i = '0;
    wb_valid_i = '0; wb_trans_id_i = '0; wb_data_i = '0; wb_ex_valid_i = '0;
    wb_ex_cause_i = '0; wb_ex_tval_i = '0; commit_ack_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic issue_one(input logic [VL-1:0] pc, input logic exv, input logic [XL-1:0] cause);
    issue_valid_i = 1'b1; issue_pc_i = pc; issue_rd_i = pc[4:0]; issue_ex_valid_i = exv;
    issue_ex_cause_i = cause; issue_ex_tval_i = exv ? XL'(pc) : '0;
    tick();
    issue_valid_i = 1'b0; issue_ex_valid_i = 1'b0; issue_ex_cause_i = '0; issue_ex_tval_i = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 1'b1;
    tick();
    n_tests++; if (issue_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", issue_ready_o); end
    n_tests++; if (issue_trans_id_o !== 3'd0) begin n_fail++; $display("FAIL reset_tid got %0d want 0", issue_trans_id_o); end
    n_tests++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %0b want 1", empty_o); end
    n_tests++; if (commit_valid_o !== 2'b00) begin n_fail++; $display("FAIL reset_cvalid got %b want 00", commit_valid_o); end
    n_tests++; if (commit_pc_o !== '0 || commit_result_o !== '0 || commit_trans_id_o !== '0) begin
      n_fail++; $display("FAIL reset_fields got pc=%0h res=%0h tid=%0h want 0", commit_pc_o, commit_result_o, commit_trans_id_o); end
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_issue_order();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (issue_trans_id_o !== 3'(i)) begin n_fail++; $display("FAIL issue_tid%0d got %0d want %0d", i, issue_trans_id_o, i); end
      issue_one(VL'(32'h100 + 4 * i), 1'b0, '0);
    end
    n_tests++; if (commit_valid_o !== 2'b00) begin n_fail++; $display("FAIL issue_cvalid got %b want 00", commit_valid_o); end
    n_tests++; if (empty_o !== 1'b0) begin n_fail++; $display("FAIL issue_empty got %0b want 0", empty_o); end
    n_tests++; if (commit_pc_o[0] !== VL'(32'h100) || commit_pc_o[1] !== VL'(32'h104)) begin
      n_fail++; $display("FAIL issue_pcs got %0h/%0h want 100/104", commit_pc_o[0], commit_pc_o[1]); end
  endtask

  task automatic test_writeback();
    wb_valid_i = 2'b01; wb_trans_id_i[0] = 3'd1; wb_data_i[0] = 64'h11;
    tick();
    n_tests++; if (commit_valid_o[0] !== 1'b0) begin n_fail++; $display("FAIL wb_slot0_early got %b want 0", commit_valid_o[0]); end
    wb_trans_id_i[0] = 3'd0; wb_data_i[0] = 64'h10;
    tick();
    wb_valid_i = 2'b00;
    n_tests++; if (commit_valid_o !== 2'b11) begin n_fail++; $display("FAIL wb_cvalid got %b want 11", commit_valid_o); end
    n_tests++; if (commit_result_o[0] !== 64'h10 || commit_result_o[1] !== 64'h11) begin
      n_fail++; $display("FAIL wb_results got %0h/%0h want 10/11", commit_result_o[0], commit_result_o[1]); end
    commit_ack_i = 2'b11;
    tick();
    commit_ack_i = 2'b00;
    n_tests++; if (commit_pc_o[0] !== VL'(32'h108) || commit_trans_id_o[0] !== 3'd2) begin
      n_fail++; $display("FAIL ack_shift got pc=%0h tid=%0d want 108/2", commit_pc_o[0], commit_trans_id_o[0]); end
    n_tests++; if (commit_valid_o !== 2'b00) begin n_fail++; $display("FAIL ack_cvalid got %b want 00", commit_valid_o); end
    commit_ack_i = 2'b01;
    tick();
    commit_ack_i = 2'b00;
    n_tests++; if (commit_pc_o[0] !== VL'(32'h108) || empty_o !== 1'b0) begin
      n_fail++; $display("FAIL ack_notdone got pc=%0h empty=%0b want 108/0", commit_pc_o[0], empty_o); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < NE; i++) issue_one(VL'(32'h200 + 4 * i), 1'b0, '0);
    n_tests++; if (issue_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready got %0b want 0", issue_ready_o); end
    wb_valid_i = 2'b01; wb_trans_id_i[0] = 3'd0; wb_data_i[0] = 64'h1;
    tick();
    wb_valid_i = 2'b00;
    commit_ack_i = 2'b01; issue_valid_i = 1'b1; issue_pc_i = VL'(32'h999);
    n_tests++; if (issue_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ack_ready got %0b want 0", issue_ready_o); end
    tick();
    commit_ack_i = 2'b00; issue_valid_i = 1'b0;
    n_tests++; if (issue_ready_o !== 1'b1 || issue_trans_id_o !== 3'd0) begin
      n_fail++; $display("FAIL full_after_ack got rdy=%0b tid=%0d want 1/0", issue_ready_o, issue_trans_id_o); end
    n_tests++; if (commit_pc_o[0] !== VL'(32'h204)) begin n_fail++; $display("FAIL full_head got %0h want 204", commit_pc_o[0]); end
    issue_one(VL'(32'h300), 1'b0, '0);
    n_tests++; if (issue_ready_o !== 1'b0) begin n_fail++; $display("FAIL wrap_full got %0b want 0", issue_ready_o); end
    for (int j = 0; j < 4; j++) begin
      wb_valid_i = 2'b11;
      wb_trans_id_i[0] = 3'(2 * j + 1); wb_data_i[0] = 64'(2 * j + 1);
      wb_trans_id_i[1] = 3'(2 * j + 2); wb_data_i[1] = (j == 3) ? 64'h55 : 64'(2 * j + 2);
      tick();
    end
    wb_valid_i = 2'b00;
    for (int j = 0; j < 3; j++) begin
      commit_ack_i = 2'b11;
      tick();
    end
    commit_ack_i = 2'b00;
    n_tests++; if (commit_pc_o[0] !== VL'(32'h21C) || commit_pc_o[1] !== VL'(32'h300)) begin
      n_fail++; $display("FAIL wrap_pcs got %0h/%0h want 21c/300", commit_pc_o[0], commit_pc_o[1]); end
    n_tests++; if (commit_trans_id_o[0] !== 3'd7 || commit_trans_id_o[1] !== 3'd0 || commit_valid_o !== 2'b11) begin
      n_fail++; $display("FAIL wrap_tids got %0d/%0d v=%b want 7/0 v=11", commit_trans_id_o[0], commit_trans_id_o[1], commit_valid_o); end
    n_tests++; if (commit_result_o[1] !== 64'h55) begin n_fail++; $display("FAIL wrap_result got %0h want 55", commit_result_o[1]); end
  endtask

  task automatic test_exception();
    do_reset();
    issue_one(VL'(32'h400), 1'b1, 64'd2);
    n_tests++; if (commit_valid_o !== 2'b01 || commit_ex_valid_o[0] !== 1'b1 || commit_ex_cause_o[0] !== 64'd2) begin
      n_fail++; $display("FAIL exc_issue got v=%b exv=%b cause=%0d want 01/1/2", commit_valid_o, commit_ex_valid_o[0], commit_ex_cause_o[0]); end
    issue_one(VL'(32'h404), 1'b0, '0);
    wb_valid_i = 2'b11; wb_trans_id_i[0] = 3'd0; wb_data_i[0] = 64'h77;
    wb_trans_id_i[1] = 3'd1; wb_data_i[1] = 64'h88; wb_ex_valid_i = 2'b10;
    wb_ex_cause_i[1] = 64'd5; wb_ex_tval_i[1] = 64'h99;
    tick();
    wb_valid_i = 2'b00; wb_ex_valid_i = 2'b00;
    n_tests++; if (commit_ex_cause_o[0] !== 64'd2 || commit_ex_valid_o[0] !== 1'b1 || commit_result_o[0] !== 64'h77) begin
      n_fail++; $display("FAIL exc_keep got cause=%0d exv=%b res=%0h want 2/1/77", commit_ex_cause_o[0], commit_ex_valid_o[0], commit_result_o[0]); end
    n_tests++; if (commit_valid_o !== 2'b11 || commit_ex_valid_o[1] !== 1'b1 || commit_ex_cause_o[1] !== 64'd5 || commit_ex_tval_o[1] !== 64'h99) begin
      n_fail++; $display("FAIL exc_wb got v=%b exv=%b cause=%0d tval=%0h want 11/1/5/99", commit_valid_o, commit_ex_valid_o[1], commit_ex_cause_o[1], commit_ex_tval_o[1]); end
  endtask

  task automatic test_same_tag();
    do_reset();
    for (int i = 0; i < 4; i++) issue_one(VL'(32'h600 + 4 * i), 1'b0, '0);
    wb_valid_i = 2'b11; wb_trans_id_i[0] = 3'd3; wb_data_i[0] = 64'hA; wb_trans_id_i[1] = 3'd3; wb_data_i[1] = 64'hB;
    tick();
    wb_trans_id_i[0] = 3'd0; wb_trans_id_i[1] = 3'd1;
    tick();
    wb_valid_i = 2'b01; wb_trans_id_i[0] = 3'd2;
    tick();
    wb_valid_i = 2'b00; commit_ack_i = 2'b11;
    tick();
    commit_ack_i = 2'b00;
    n_tests++; if (commit_result_o[1] !== 64'hB || commit_trans_id_o[1] !== 3'd3 || commit_valid_o !== 2'b11) begin
      n_fail++; $display("FAIL same_tag got res=%0h tid=%0d v=%b want b/3/11", commit_result_o[1], commit_trans_id_o[1], commit_valid_o); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) issue_one(VL'(32'h700 + 4 * i), 1'b0, '0);
    wb_valid_i = 2'b11; wb_trans_id_i[0] = 3'd0; wb_trans_id_i[1] = 3'd1;
    tick();
    wb_valid_i = 2'b00;
    flush_i = 1'b1; issue_valid_i = 1'b1; issue_pc_i = VL'(32'h7FF); commit_ack_i = 2'b11;
    tick();
    flush_i = 1'b0; issue_valid_i = 1'b0; commit_ack_i = 2'b00;
    n_tests++; if (empty_o !== 1'b1 || issue_trans_id_o !== 3'd0 || commit_valid_o !== 2'b00 || issue_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL flush got empty=%0b tid=%0d v=%b rdy=%0b want 1/0/00/1", empty_o, issue_trans_id_o, commit_valid_o, issue_ready_o); end
    issue_one(VL'(32'h500), 1'b0, '0);
    n_tests++; if (commit_pc_o[0] !== VL'(32'h500) || commit_trans_id_o[0] !== 3'd0 || empty_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_reissue got pc=%0h tid=%0d empty=%0b want 500/0/0", commit_pc_o[0], commit_trans_id_o[0], empty_o); end
    rst_i = 1'b1;
    tick();
    n_tests++; if (commit_pc_o !== '0 || empty_o !== 1'b1 || commit_valid_o !== 2'b00) begin
      n_fail++; $display("FAIL midreset got pc=%0h empty=%0b v=%b want 0/1/00", commit_pc_o, empty_o, commit_valid_o); end
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    test_reset();
    test_issue_order();
    test_writeback();
    test_full_wrap();
    test_exception();
    test_same_tag();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
